// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multicycle RV32I control unit: opcodes, FSM states,
// ALU operation codes and datapath mux select encodings.
package riscv_mc_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_mc_alu_dec.sv
// ALU operation decode from funct3/funct7b5; flags funct3 values the ALU
// cannot execute so the FSM can trap them like an illegal opcode.
module riscv_mc_alu_dec
  import riscv_mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct3)
      // Only R-type honours funct7b5; for addi bit 30 is immediate data.
      3'b000:  alu_control = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Moore control FSM for the multicycle RV32I datapath, with memory wait states,
// illegal-instruction halt and a retired-instruction counter.
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int ALU_CTRL_W      = 3,
  parameter int WAIT_EN         = 1,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_write,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired,
  output logic [3:0]            state_dbg
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             rdy;
  logic [2:0]       dec_alu;
  logic             funct_illegal;
  logic [2:0]       alu_c;
  logic             pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  // Memory handshake: mem_ready high in a cycle means the access presented in
  // that cycle completes on the coming clock edge; low stretches the state.
  assign rdy = (WAIT_EN != 0) ? mem_ready : 1'b1;

  riscv_mc_alu_dec u_alu_dec (
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .alu_control  (dec_alu),
    .funct_illegal(funct_illegal)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            if (HALT_ON_ILLEGAL != 0) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI: begin
        if (!funct_illegal) begin
          state_d = S_ALUWB;
        end else if (HALT_ON_ILLEGAL != 0) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL:   state_d = S_ALUWB;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALU;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RD2;
    imm_src     = IMM_I;
    alu_c       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        ir_write_c = rdy;
        pc_write_c = rdy;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        result_src  = RES_ALUOUT;
        mem_write_c = rdy;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        alu_c     = dec_alu;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_c     = dec_alu;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_RD2;
        alu_c      = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write_c = zero;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset lands in FETCH, whose enables would otherwise follow mem_ready.
  assign pc_write    = pc_write_c & reset;
  assign mem_write   = mem_write_c & reset;
  assign ir_write    = ir_write_c & reset;
  assign reg_write   = reg_write_c & reset;
  assign alu_control = ALU_CTRL_W'(alu_c);
  assign illegal     = (state_q == S_HALT);
  assign retired     = retired_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: per-cycle vector table plus
// hand-written halt, reset-abort and no-wait-state sequences.
module tb_riscv_mc_control;
  import riscv_mc_pkg::*;

  localparam int W = 53;

  typedef struct {
    logic       rdy;
    logic       z;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] st;
    logic [2:0] alu;
    logic [31:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset_nw = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_ready_nw = 1'b0;

  logic pc_write_m, adr_src_m, mem_write_m, ir_write_m, reg_write_m, illegal_m;
  logic [1:0] result_src_m, alu_src_a_m, alu_src_b_m, imm_src_m;
  logic [2:0] alu_control_m;
  logic [31:0] retired_m;
  logic [3:0] state_dbg_m;

  logic pc_write_n, adr_src_n, mem_write_n, ir_write_n, reg_write_n, illegal_n;
  logic [1:0] result_src_n, alu_src_a_n, alu_src_b_n, imm_src_n;
  logic [2:0] alu_control_n;
  logic [31:0] retired_n;
  logic [3:0] state_dbg_n;

  logic [16:0] act_m, act_n;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  riscv_mc_control #(.ALU_CTRL_W(3), .WAIT_EN(1), .HALT_ON_ILLEGAL(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write_m), .adr_src(adr_src_m),
    .mem_write(mem_write_m), .ir_write(ir_write_m), .result_src(result_src_m),
    .alu_src_a(alu_src_a_m), .alu_src_b(alu_src_b_m), .imm_src(imm_src_m),
    .alu_control(alu_control_m), .reg_write(reg_write_m), .illegal(illegal_m),
    .retired(retired_m), .state_dbg(state_dbg_m)
  );

  riscv_mc_control #(.ALU_CTRL_W(3), .WAIT_EN(0), .HALT_ON_ILLEGAL(0), .CNT_W(32)) dut_nw (
    .clk(clk), .reset(reset_nw), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready_nw), .pc_write(pc_write_n), .adr_src(adr_src_n),
    .mem_write(mem_write_n), .ir_write(ir_write_n), .result_src(result_src_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .imm_src(imm_src_n),
    .alu_control(alu_control_n), .reg_write(reg_write_n), .illegal(illegal_n),
    .retired(retired_n), .state_dbg(state_dbg_n)
  );

  assign act_m = {pc_write_m, adr_src_m, mem_write_m, ir_write_m, result_src_m, alu_src_a_m,
                  alu_src_b_m, imm_src_m, alu_control_m, reg_write_m, illegal_m};
  assign act_n = {pc_write_n, adr_src_n, mem_write_n, ir_write_n, result_src_n, alu_src_a_n,
                  alu_src_b_n, imm_src_n, alu_control_n, reg_write_n, illegal_n};

  // Expected control word for a state, straight from the state/output table.
  function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic rdy, input logic z,
                                           input logic [6:0] o, input logic [2:0] alu,
                                           input logic rst);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] ac;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; imm = 2'b00; ac = 3'b000;
    case (st)
      4'd0:  begin sb = 2'b10; irw = rdy; pcw = rdy; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; imm = 2'b10; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; imm = (o == 7'b0100011) ? 2'b01 : 2'b00; end
      4'd3:  begin adr = 1; rs = 2'b10; end
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; rs = 2'b10; mw = rdy; end
      4'd6:  begin sa = 2'b10; sb = 2'b00; ac = alu; end
      4'd7:  begin sa = 2'b10; sb = 2'b01; ac = alu; end
      4'd8:  begin rs = 2'b10; rw = 1; end
      4'd9:  begin sa = 2'b10; ac = 3'b001; rs = 2'b10; pcw = z; end
      4'd10: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; pcw = 1; end
      4'd11: ill = 1;
      default: ;
    endcase
    if (!rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, imm, ac, rw, ill};
  endfunction

  task automatic step(input logic which, input logic rst, input logic rdy, input logic z,
                      input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic [3:0] st, input logic [2:0] alu, input logic [31:0] ret,
                      input string tag);
    logic [W-1:0] act, e;
    @(negedge clk);
    if (which) reset_nw = rst; else reset = rst;
    mem_ready = rdy; zero = z; op = o; funct3 = f3; funct7b5 = f7;
    exp_q.push_back({st, exp_outs(st, which ? 1'b1 : rdy, z, o, alu, rst), ret});
    #1;
    act = which ? {state_dbg_n, act_n, retired_n} : {state_dbg_m, act_m, retired_m};
    e = exp_q.pop_front();
    checks++;
    if (act !== e)
      $display("FAIL %s: got state/outs/retired %h, expected %h", tag, act, e);
    else
      passed++;
  endtask

  task automatic add(input logic rdy, input logic z, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic [3:0] st, input logic [2:0] alu,
                     input logic [31:0] ret);
    vec_t v;
    v.rdy = rdy; v.z = z; v.op = o; v.f3 = f3; v.f7 = f7; v.st = st; v.alu = alu; v.ret = ret;
    vecs.push_back(v);
  endtask

  initial begin
    // R-type sub
    add(1,0,OP_R,3'd0,1,4'd0,3'd0,0); add(1,0,OP_R,3'd0,1,4'd1,3'd0,0);
    add(1,0,OP_R,3'd0,1,4'd6,3'd1,0); add(1,0,OP_R,3'd0,1,4'd8,3'd0,0);
    // lw with 2 FETCH and 3 MEMREAD wait cycles
    add(0,0,OP_LOAD,3'd2,0,4'd0,3'd0,1); add(0,0,OP_LOAD,3'd2,0,4'd0,3'd0,1);
    add(1,0,OP_LOAD,3'd2,0,4'd0,3'd0,1); add(1,0,OP_LOAD,3'd2,0,4'd1,3'd0,1);
    add(1,0,OP_LOAD,3'd2,0,4'd2,3'd0,1); add(0,0,OP_LOAD,3'd2,0,4'd3,3'd0,1);
    add(0,0,OP_LOAD,3'd2,0,4'd3,3'd0,1); add(0,0,OP_LOAD,3'd2,0,4'd3,3'd0,1);
    add(1,0,OP_LOAD,3'd2,0,4'd3,3'd0,1); add(1,0,OP_LOAD,3'd2,0,4'd4,3'd0,1);
    // beq taken then not taken
    add(1,1,OP_BEQ,3'd0,0,4'd0,3'd0,2); add(1,1,OP_BEQ,3'd0,0,4'd1,3'd0,2);
    add(1,1,OP_BEQ,3'd0,0,4'd9,3'd0,2);
    add(1,0,OP_BEQ,3'd0,0,4'd0,3'd0,3); add(1,0,OP_BEQ,3'd0,0,4'd1,3'd0,3);
    add(1,0,OP_BEQ,3'd0,0,4'd9,3'd0,3);
    // jal
    add(1,0,OP_JAL,3'd0,0,4'd0,3'd0,4); add(1,0,OP_JAL,3'd0,0,4'd1,3'd0,4);
    add(1,0,OP_JAL,3'd0,0,4'd10,3'd0,4); add(1,0,OP_JAL,3'd0,0,4'd8,3'd0,4);
    // addi with bit30 set stays add
    add(1,0,OP_I,3'd0,1,4'd0,3'd0,5); add(1,0,OP_I,3'd0,1,4'd1,3'd0,5);
    add(1,0,OP_I,3'd0,1,4'd7,3'd0,5); add(1,0,OP_I,3'd0,1,4'd8,3'd0,5);
    // sw with one MEMWRITE wait
    add(1,0,OP_STORE,3'd2,0,4'd0,3'd0,6); add(1,0,OP_STORE,3'd2,0,4'd1,3'd0,6);
    add(1,0,OP_STORE,3'd2,0,4'd2,3'd0,6); add(0,0,OP_STORE,3'd2,0,4'd5,3'd0,6);
    add(1,0,OP_STORE,3'd2,0,4'd5,3'd0,6);
    // or, slt, and
    add(1,0,OP_R,3'd6,0,4'd0,3'd0,7); add(1,0,OP_R,3'd6,0,4'd1,3'd0,7);
    add(1,0,OP_R,3'd6,0,4'd6,3'd3,7); add(1,0,OP_R,3'd6,0,4'd8,3'd0,7);
    add(1,0,OP_R,3'd2,0,4'd0,3'd0,8); add(1,0,OP_R,3'd2,0,4'd1,3'd0,8);
    add(1,0,OP_R,3'd2,0,4'd6,3'd5,8); add(1,0,OP_R,3'd2,0,4'd8,3'd0,8);
    add(1,0,OP_R,3'd7,0,4'd0,3'd0,9); add(1,0,OP_R,3'd7,0,4'd1,3'd0,9);
    add(1,0,OP_R,3'd7,0,4'd6,3'd2,9); add(1,0,OP_R,3'd7,0,4'd8,3'd0,9);

    repeat (3) @(posedge clk);
    step(0, 0, 1, 0, OP_R, 3'd0, 1, 4'd0, 3'd0, 0, "reset_state");
    foreach (vecs[i])
      step(0, 1, vecs[i].rdy, vecs[i].z, vecs[i].op, vecs[i].f3, vecs[i].f7,
           vecs[i].st, vecs[i].alu, vecs[i].ret, $sformatf("vec%0d", i));

    // Illegal opcode: sticky HALT regardless of mem_ready/zero
    step(0, 1, 1, 0, 7'h7f, 3'd0, 0, 4'd0, 3'd0, 10, "ill_fetch");
    step(0, 1, 1, 0, 7'h7f, 3'd0, 0, 4'd1, 3'd0, 10, "ill_decode");
    for (int i = 0; i < 20; i++)
      step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'h7f, 3'd0, 0,
           4'd11, 3'd0, 10, "halt_hold");
    step(0, 0, 1, 0, 7'h7f, 3'd0, 0, 4'd0, 3'd0, 0, "halt_reset");

    // Unsupported funct3 on an R-type traps from EXECR
    step(0, 1, 1, 0, OP_R, 3'd1, 0, 4'd0, 3'd0, 0, "f3ill_fetch");
    step(0, 1, 1, 0, OP_R, 3'd1, 0, 4'd1, 3'd0, 0, "f3ill_decode");
    step(0, 1, 1, 0, OP_R, 3'd1, 0, 4'd6, 3'd0, 0, "f3ill_exec");
    step(0, 1, 1, 0, OP_R, 3'd1, 0, 4'd11, 3'd0, 0, "f3ill_halt");
    step(0, 0, 1, 0, OP_R, 3'd1, 0, 4'd0, 3'd0, 0, "f3ill_reset");

    // Reset falls mid-MEMWRITE while the store is still waiting
    step(0, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd0, 3'd0, 0, "swrst_fetch");
    step(0, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd1, 3'd0, 0, "swrst_decode");
    step(0, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd2, 3'd0, 0, "swrst_memadr");
    step(0, 1, 0, 0, OP_STORE, 3'd2, 0, 4'd5, 3'd0, 0, "swrst_wait1");
    step(0, 1, 0, 0, OP_STORE, 3'd2, 0, 4'd5, 3'd0, 0, "swrst_wait2");
    step(0, 0, 0, 0, OP_STORE, 3'd2, 0, 4'd0, 3'd0, 0, "swrst_async");
    step(0, 0, 1, 0, OP_STORE, 3'd2, 0, 4'd0, 3'd0, 0, "swrst_held");
    step(0, 1, 0, 0, OP_STORE, 3'd2, 0, 4'd0, 3'd0, 0, "swrst_release");
    step(0, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd0, 3'd0, 0, "swrst_fetch2");
    step(0, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd1, 3'd0, 0, "swrst_decode2");

    // WAIT_EN=0 / HALT_ON_ILLEGAL=0 instance; its mem_ready is held low
    step(1, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd0, 3'd0, 0, "nw_sw_fetch");
    step(1, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd1, 3'd0, 0, "nw_sw_decode");
    step(1, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd2, 3'd0, 0, "nw_sw_memadr");
    step(1, 1, 1, 0, OP_STORE, 3'd2, 0, 4'd5, 3'd0, 0, "nw_sw_memwrite");
    step(1, 1, 1, 0, 7'h7f, 3'd0, 0, 4'd0, 3'd0, 1, "nw_nop_fetch");
    step(1, 1, 1, 0, 7'h7f, 3'd0, 0, 4'd1, 3'd0, 1, "nw_nop_decode");
    step(1, 1, 1, 0, OP_LOAD, 3'd2, 0, 4'd0, 3'd0, 2, "nw_lw_fetch");
    step(1, 1, 1, 0, OP_LOAD, 3'd2, 0, 4'd1, 3'd0, 2, "nw_lw_decode");
    step(1, 1, 1, 0, OP_LOAD, 3'd2, 0, 4'd2, 3'd0, 2, "nw_lw_memadr");
    step(1, 1, 1, 0, OP_LOAD, 3'd2, 0, 4'd3, 3'd0, 2, "nw_lw_memread");
    step(1, 1, 1, 0, OP_LOAD, 3'd2, 0, 4'd4, 3'd0, 2, "nw_lw_memwb");
    step(1, 1, 1, 0, OP_R, 3'd0, 0, 4'd0, 3'd0, 3, "nw_end");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Parametrised multicycle RV32I control unit. It sequences the existing multicycle datapath: loadRegs, RegisterFile, Extend, the three 3-way Multiplex instances, ALU, ALUOut and Data registers.
- A Moore FSM drives every mux select, write enable and ALU control, derived from op/funct fields.
- Adds an optional memory wait-state handshake, an illegal-instruction trap/halt, and a retired-instruction counter.

Parameters:
- ALU_CTRL_W, 3: width of alu_control.
- WAIT_EN, 1: 1 = honour mem_ready; 0 = mem_ready internally tied to 1.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters sticky HALT; 0 = treat it as NOP and return to FETCH.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  instruction[6:0] from instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU Zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC register load
- adr_src  out  1  memory address: 0 = PC, 1 = result
- mem_write  out  1  memory write strobe
- ir_write  out  1  loads oldPC/instruction (IRWrite)
- result_src  out  2  00 = ALUResult, 01 = Data, 10 = ALUOut
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = RD1 register
- alu_src_b  out  2  00 = RD2 register, 01 = immExt, 10 = constant 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  RegisterFile WE3
- illegal  out  1  high while in HALT
- retired  out  CNT_W  count of completed instructions
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (reset low, async):
  - State goes to FETCH; retired = 0; illegal = 0.
  - All enables (pc_write, ir_write, mem_write, reg_write) are forced to 0 while reset is low.
  - Operation starts on the first rising clk edge after reset goes high.
- Outputs are a pure function of state, except:
  - pc_write in BEQ = zero.
  - ir_write/pc_write in FETCH and mem_write in MEMWRITE are qualified by the effective mem_ready.
- States, outputs and transitions. "rdy" is the effective mem_ready. Unlisted outputs are 0 (alu_control add).
  - FETCH (0): adr_src 0, alu_src_a 00, alu_src_b 10, add, result_src 00. ir_write = pc_write = rdy. Go to DECODE if rdy, else stay.
  - DECODE (1): alu_src_a 01, alu_src_b 01, add, imm_src 10 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> HALT if HALT_ON_ILLEGAL, else FETCH with retired+1
  - MEMADR (2): alu_src_a 10, alu_src_b 01, add; imm_src 00 for load, 01 for store. Load -> MEMREAD; store -> MEMWRITE.
  - MEMREAD (3): adr_src 1, result_src 10. Go to MEMWB on rdy, else stay.
  - MEMWB (4): result_src 01, reg_write 1. Go to FETCH.
  - MEMWRITE (5): adr_src 1, result_src 10, mem_write = rdy. Go to FETCH on rdy.
  - EXECR (6): alu_src_a 10, alu_src_b 00, ALU decode. Go to ALUWB.
  - EXECI (7): alu_src_a 10, alu_src_b 01, imm_src 00, ALU decode. Go to ALUWB.
  - ALUWB (8): result_src 10, reg_write 1. Go to FETCH.
  - BEQ (9): alu_src_a 10, alu_src_b 00, sub, result_src 10, pc_write = zero. Go to FETCH.
  - JAL (10): alu_src_a 01, alu_src_b 10, add, result_src 10, pc_write 1. Go to ALUWB.
  - HALT (11): illegal 1, all enables 0. Stays in HALT until reset.
- ALU decode by funct3:
  - 000: sub only when op = 0110011 and funct7b5 = 1; otherwise add (including op = 0010011, so addi is never sub).
  - 010: slt. 110: or. 111: and.
  - Other funct3 values: add, and the instruction is flagged illegal, handled as for an illegal opcode on the EXECR/EXECI -> ALUWB transition.
- retired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and on the illegal-NOP transition.
  - Wraps modulo 2^CNT_W.
  - Never increments in HALT.
- Latencies with rdy = 1 every cycle: lw 5 cycles, sw 4, R/I-type 4, beq 3, jal 4.
- Each wait cycle (rdy = 0) adds exactly 1 cycle, with outputs held stable during the wait.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after reset falls, and retired is not incremented.

Decomposition:
- Package riscv_mc_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BEQ);
  - state encodings;
  - ALU_ADD/SUB/AND/OR/SLT codes;
  - SRC_A_*, SRC_B_*, RES_*, IMM_* select constants.
- One combinational sub-module riscv_mc_alu_dec takes (op, funct3, funct7b5) and returns {alu_control, funct_illegal}.

Test Plan:
- Reset released, WAIT_EN=1, mem_ready=1, op=0110011, f3=000, f7b5=1 -> states 0,1,6,8,0. alu_control=001 in EXECR, reg_write=1 only in ALUWB, retired=1.
- lw (op 0000011) with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> FETCH held 3 cycles, MEMREAD held 4 cycles. ir_write pulses once. reg_write=1 with result_src=01 in MEMWB. Total 10 cycles.
- beq, zero=1 then zero=0 -> pc_write=1 in BEQ only for zero=1. alu_control=001, alu_src_a=10. 3 cycles each; retired increments by 2.
- jal -> states 0,1,10,8. JAL: pc_write=1, alu_src_a=01, alu_src_b=10. ALUWB: reg_write=1.
- op=1111111, HALT_ON_ILLEGAL=1 -> state 11, illegal=1, all enables 0 for 20 cycles. Reset low then high -> FETCH, retired=0.
- Reset driven low during MEMWRITE while mem_ready=0 -> mem_write stays 0 and state_dbg=0 asynchronously. With WAIT_EN=0 and mem_ready=0 held -> sw completes in 4 cycles.
